// File: rtl/seq_multiplier.sv
// seq_multiplier: 24x24 -> 48-bit radix-2 shift-add multiplier.
// One step per clock. Start is captured at E0, the steps run on E1..E24,
// Product is loaded on E25, and Done/MulRegWrite pulse for the cycle after that.
// Build option: define SIGNED_MUL_EN to let the signed_mode input choose
// two's-complement operands. When it is undefined every multiply is unsigned
// and no sign-correction logic is built.
//
// state | meaning
// IDLE  | waiting for start; busy low
// RUN   | 24 shift-add steps, then the product load
// DONE  | done/mul_reg_write pulse for one cycle; start is ignored here
module seq_multiplier (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic        signed_mode,
   input  logic [23:0] operand_a,
   input  logic [23:0] operand_b,
   output logic        busy,
   output logic        done,
   output logic [47:0] product,
   output logic        mul_reg_write
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [4:0] LAST_STEP = 5'd24;

   state_t      state;
   state_t      state_nxt;
   logic [4:0]  count;
   logic [47:0] acc;
   logic [47:0] mcand;
   logic [23:0] mplier;
   logic [23:0] a_mag;
   logic [23:0] b_mag;
   logic [47:0] product_load;

`ifdef SIGNED_MUL_EN
   logic a_neg;
   logic b_neg;
   logic neg;

   // Form the operand magnitudes. 24'h800000 negates to itself, which read as
   // an unsigned value is exactly 2^23.
   assign a_neg        = signed_mode & operand_a[23];
   assign b_neg        = signed_mode & operand_b[23];
   assign a_mag        = a_neg ? (24'd0 - operand_a) : operand_a;
   assign b_mag        = b_neg ? (24'd0 - operand_b) : operand_b;
   assign product_load = neg ? (48'd0 - acc) : acc;

   // Record whether the result must be negated, taken at the moment of capture.
   always_ff @(posedge clock) begin
      if (!reset_n)
         neg <= 1'b0;
      else if (state == IDLE && start)
         neg <= a_neg ^ b_neg;
   end
`else
   logic unused_signed_mode;

   assign unused_signed_mode = signed_mode;
   assign a_mag              = operand_a;
   assign b_mag              = operand_b;
   assign product_load       = acc;
`endif

   // State register.
   always_ff @(posedge clock) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start)
               state_nxt = RUN;
         end
         RUN: begin
            if (count == LAST_STEP)
               state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign mul_reg_write = done;

   // Datapath: capture the operands, run the shift-add steps, load the product.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         count   <= 5'd0;
         acc     <= 48'd0;
         mcand   <= 48'd0;
         mplier  <= 24'd0;
         product <= 48'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mcand  <= {24'd0, a_mag};
                  mplier <= b_mag;
                  acc    <= 48'd0;
                  count  <= 5'd0;
               end
            end
            RUN: begin
               if (count == LAST_STEP) begin
                  product <= product_load;
               end else begin
                  if (mplier[0])
                     acc <= acc + mcand;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  count  <= count + 5'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier. It checks the results against a
// 64-bit arithmetic reference and follows SIGNED_MUL_EN the same way the design does.
module tb_seq_multiplier;

   logic        clock;
   logic        reset_n;
   logic        start;
   logic        signed_mode;
   logic [23:0] operand_a;
   logic [23:0] operand_b;
   logic        busy;
   logic        done;
   logic [47:0] product;
   logic        mul_reg_write;

   int          checks;
   int          errors;
   logic [47:0] last_product;

   seq_multiplier dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .start         (start),
      .signed_mode   (signed_mode),
      .operand_a     (operand_a),
      .operand_b     (operand_b),
      .busy          (busy),
      .done          (done),
      .product       (product),
      .mul_reg_write (mul_reg_write)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [47:0] ref_mul(input logic [23:0] a, input logic [23:0] b,
                                           input logic s);
      longint x;
      longint y;
      longint p;
      x = {40'd0, a};
      y = {40'd0, b};
`ifdef SIGNED_MUL_EN
      if (s) begin
         x = longint'($signed(a));
         y = longint'($signed(b));
      end
`endif
      p = x * y;
      return p[47:0];
   endfunction

   // Full transaction. The operands are scrambled while the multiply runs.
   task automatic run_mul(input logic [23:0] a, input logic [23:0] b, input logic s,
                          input logic [47:0] expected, input string name);
      int done_edge;
      int done_cnt;
      done_edge = -1;
      done_cnt  = 0;
      @(negedge clock);
      operand_a   = a;
      operand_b   = b;
      signed_mode = s;
      start       = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      for (int i = 1; i <= 30; i++) begin
         @(posedge clock);
         #1;
         operand_a   = 24'($urandom);
         operand_b   = 24'($urandom);
         signed_mode = 1'($urandom);
         checks++;
         if (mul_reg_write !== done) begin
            errors++;
            $display("FAIL %s strobe edge %0d: mul_reg_write=%b done=%b", name, i, mul_reg_write, done);
         end
         if (done === 1'b1) begin
            done_cnt++;
            if (done_edge < 0) done_edge = i;
         end
         if (i < 25 || i == 26) begin
            checks++;
            if (busy !== (i < 25)) begin
               errors++;
               $display("FAIL %s busy edge %0d: got %b expected %b", name, i, busy, (i < 25));
            end
         end
         if (i == 12) begin
            checks++;
            if (product !== last_product) begin
               errors++;
               $display("FAIL %s hold: got %h expected %h", name, product, last_product);
            end
         end
      end
      checks++;
      if (done_edge != 25) begin
         errors++;
         $display("FAIL %s latency: got %0d expected 25", name, done_edge);
      end
      checks++;
      if (done_cnt != 1) begin
         errors++;
         $display("FAIL %s done count: got %0d expected 1", name, done_cnt);
      end
      checks++;
      if (product !== expected) begin
         errors++;
         $display("FAIL %s product: got %h expected %h", name, product, expected);
      end
      last_product = expected;
   endtask

   task automatic test_reset();
      reset_n     = 1'b0;
      start       = 1'b1;
      signed_mode = 1'b0;
      operand_a   = 24'd7;
      operand_b   = 24'd9;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if ({busy, done, mul_reg_write} !== 3'b000 || product !== 48'd0) begin
         errors++;
         $display("FAIL reset: got busy=%b done=%b mrw=%b product=%h expected 0/0/0/0",
                  busy, done, mul_reg_write, product);
      end
      start        = 1'b0;
      last_product = 48'd0;
   endtask

   task automatic test_first_start();
      reset_n = 1'b1;
      run_mul(24'd3, 24'd4, 1'b0, 48'd12, "first_start");
   endtask

   task automatic test_directed();
      run_mul(24'hFFFFFF, 24'hFFFFFF, 1'b0, 48'hFFFFFE000001, "max_unsigned");
      run_mul(24'h000000, 24'h123456, 1'b0, 48'h0, "zero_a");
`ifdef SIGNED_MUL_EN
      run_mul(24'hFFFFFD, 24'd5, 1'b1, 48'hFFFFFFFFFFF1, "signed_neg3x5");
      run_mul(24'h800000, 24'h800000, 1'b1, 48'h400000000000, "signed_min_sq");
      run_mul(24'hFFFFFF, 24'hFFFFFF, 1'b1, 48'h1, "signed_m1_sq");
`else
      run_mul(24'hFFFFFF, 24'hFFFFFF, 1'b1, 48'hFFFFFE000001, "signed_ignored");
`endif
   endtask

   task automatic test_random();
      logic [23:0] a;
      logic [23:0] b;
      logic        s;
      for (int n = 0; n < 16; n++) begin
         a = 24'($urandom);
         b = 24'($urandom);
         s = 1'($urandom);
         if (n == 3) a = 24'h800000;
         if (n == 5) b = 24'h000001;
         run_mul(a, b, s, ref_mul(a, b, s), "random");
      end
   endtask

   // A start raised during RUN, and another raised during DONE, must both be ignored.
   task automatic test_busy_ignore();
      int done_cnt;
      int done_edge;
      done_cnt  = 0;
      done_edge = -1;
      @(negedge clock);
      operand_a   = 24'd1000;
      operand_b   = 24'd2000;
      signed_mode = 1'b0;
      start       = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clock);
         #1;
         if (done === 1'b1) begin
            done_cnt++;
            if (done_edge < 0) done_edge = i;
         end
         if (i == 9 || i == 25) begin
            operand_a = 24'd7;
            operand_b = 24'd9;
            start     = 1'b1;
         end
         if (i == 10 || i == 26) start = 1'b0;
         if (i == 26 || i == 27) begin
            checks++;
            if (busy !== 1'b0) begin
               errors++;
               $display("FAIL busy_ignore idle edge %0d: got busy=%b expected 0", i, busy);
            end
         end
      end
      checks++;
      if (done_cnt != 1 || done_edge != 25) begin
         errors++;
         $display("FAIL busy_ignore done: got count=%0d edge=%0d expected 1 at 25", done_cnt, done_edge);
      end
      checks++;
      if (product !== 48'h0000001E8480) begin
         errors++;
         $display("FAIL busy_ignore product: got %h expected 0000001e8480", product);
      end
      last_product = 48'h0000001E8480;
   endtask

   task automatic test_reset_mid_op();
      int done_cnt;
      done_cnt = 0;
      @(negedge clock);
      operand_a   = 24'h00ABCD;
      operand_b   = 24'h001234;
      signed_mode = 1'b0;
      start       = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clock);
         #1;
         if (done === 1'b1) done_cnt++;
         if (i == 11) reset_n = 1'b0;
         if (i == 12) begin
            checks++;
            if (busy !== 1'b0 || product !== 48'd0) begin
               errors++;
               $display("FAIL reset_mid_op: got busy=%b product=%h expected 0/0", busy, product);
            end
            reset_n = 1'b1;
         end
      end
      checks++;
      if (done_cnt != 0) begin
         errors++;
         $display("FAIL reset_mid_op done: got %0d pulses expected 0", done_cnt);
      end
      last_product = 48'd0;
      run_mul(24'd1234, 24'd5678, 1'b0, 48'd7006652, "after_reset");
   endtask

   // Start held high all the time: one multiply is accepted every 27 edges.
   task automatic test_back_to_back();
      int done_cnt;
      int edges[$];
      done_cnt = 0;
      @(negedge clock);
      operand_a   = 24'd12345;
      operand_b   = 24'd678;
      signed_mode = 1'b0;
      start       = 1'b1;
      @(posedge clock);
      #1;
      for (int i = 1; i <= 85; i++) begin
         @(posedge clock);
         #1;
         if (done === 1'b1) begin
            done_cnt++;
            edges.push_back(i);
            checks++;
            if (product !== 48'd8369910) begin
               errors++;
               $display("FAIL back_to_back product: got %h expected %h", product, 48'd8369910);
            end
         end
      end
      start = 1'b0;
      checks++;
      if (done_cnt != 3 || edges.size() != 3 || edges[0] != 25 || edges[1] != 52 || edges[2] != 79) begin
         errors++;
         $display("FAIL back_to_back timing: got %0d pulses expected 3 at 25/52/79", done_cnt);
      end
      repeat (3) @(posedge clock);
      last_product = 48'd8369910;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_first_start();
      test_directed();
      test_busy_ignore();
      test_reset_mid_op();
      test_random();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset.
REQ-002 Clock  input  1  rising-edge clock for all state.
REQ-003 ResetN  input  1  synchronous active-low reset, sampled on the Clock rising edge.
REQ-004 Start  input  1  request to begin a multiply, sampled only in IDLE.
REQ-005 Signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with Start.
REQ-006 OperandA  input  24  multiplicand.
REQ-007 OperandB  input  24  multiplier.
REQ-008 Busy  output  1  high whenever state is not IDLE.
REQ-009 Done  output  1  one-cycle pulse when Product holds a new result.
REQ-010 Product  output  48  registered full-width result; drives the 48-bit multiply result register's WriteData.
REQ-011 MulRegWrite  output  1  write strobe to the multiply result register; identical to Done.

Function
REQ-012 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-013 IDLE with Start=1 at edge E0: SHALL capture OperandA, OperandB and Signed, clear the 48-bit accumulator and the 5-bit counter, and move to RUN.
REQ-014 RUN: SHALL perform one radix-2 shift-add step per edge (if multiplier LSB=1, add shifted multiplicand; shift multiplicand left 1 and multiplier right 1); increment counter.
REQ-015 Iterations: exactly 24 steps on edges E1..E24; no early termination for zero or small operands.
REQ-016 Edge E25: SHALL load Product from the accumulator (sign-corrected per REQ-017) and move to DONE.
REQ-017 Sign correction: magnitudes SHALL be formed at capture; result negated (two's complement, 48-bit) when the signs differ.
REQ-018 Sign correction: 24'h800000 SHALL be treated as magnitude 2^23.
REQ-019 DONE: Done=MulRegWrite=1 for exactly one cycle; the next edge returns to IDLE.
REQ-020 Latency: Start sampled at E0 -> Done high in the cycle after E25; throughput one multiply per 27 edges minimum.
REQ-021 Start while Busy=1 (RUN or DONE) SHALL be ignored; operand changes during RUN SHALL NOT affect the result.
REQ-022 Product SHALL hold its value from DONE until the next E25 load.
REQ-023 Start in the same cycle as DONE SHALL be ignored.
REQ-024 Arithmetic SHALL be full precision: no overflow or truncation, 48-bit result for all operand pairs.

Reset
REQ-025 ResetN=0 at an edge SHALL force IDLE, Product=0, Done=0, MulRegWrite=0, Busy=0, and clear the counter and accumulator.
REQ-026 Reset SHALL take precedence over Start and over any in-flight operation; an aborted multiply SHALL produce no Done pulse.
REQ-027 First Start accepted on the first edge with ResetN=1.

Configuration
REQ-028 Macro SIGNED_MUL_EN defined: the Signed input SHALL select signed/unsigned behaviour per REQ-017 and REQ-018.
REQ-029 Macro SIGNED_MUL_EN undefined: the Signed port SHALL remain present but be ignored; all operations SHALL be unsigned and no sign-correction logic SHALL be built.
REQ-030 Latency and handshake SHALL be identical in both configurations.

Verification
REQ-031 Unsigned: A=24'hFFFFFF, B=24'hFFFFFF, Signed=0 -> Product=48'hFFFFFE000001, Done pulse exactly 25 edges after Start, MulRegWrite coincident.
REQ-032 Signed (SIGNED_MUL_EN): A=-3 (24'hFFFFFD), B=5 -> Product=48'hFFFFFFFFFFF1; A=24'h800000, B=24'h800000 -> Product=48'h400000000000.
REQ-033 Without SIGNED_MUL_EN: A=24'hFFFFFF, B=24'hFFFFFF, Signed=1 -> Product=48'hFFFFFE000001 (unsigned).
REQ-034 Busy ignore: start 1000*2000, pulse Start with other operands at E10 -> single Done, Product=48'h0000001E8480.
REQ-035 Reset mid-op: ResetN=0 at E12 -> next cycle Busy=0, Product=0; no Done pulse; new Start afterwards completes normally.
REQ-036 Zero operand: A=0, B=24'h123456 -> Product=0 after the full 25-edge latency.
